seq_fixed_div: RTL
==================

# seq_fixed_div

Multi-cycle radix-2 restoring divider for the team's sign-magnitude Q16.16 fixed-point format. It is the inverse counterpart of the combinational `mult` operator: given a dividend and a divisor, it produces an exact truncated quotient, with saturation and divide-by-zero flags. It sits beside the combinational operators in equation high-level synthesis and replaces the Newton-Raphson `div` wherever exact results matter more than latency. It uses a valid/ready handshake on both input and output.

## Interface
Parameters:
- `N`, 32: total word width, sign-magnitude; bit N-1 is the sign.
- `Q`, 16: fractional bits.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: `a` and `b` are valid.
- `in_ready`  out  1: the divider can accept an operand pair.
- `a`  in  N: dividend, sign-magnitude Q(N-Q-1).Q.
- `b`  in  N: divisor, same format.
- `out_valid`  out  1: `c` and the flags are valid.
- `out_ready`  in  1: the consumer takes the result.
- `c`  out  N: quotient, sign-magnitude.
- `ovf`  out  1: the quotient magnitude saturated.
- `div_zero`  out  1: `b` magnitude was zero.

## Operation
- Magnitudes: `ma = a[N-2:0]`, `mb = b[N-2:0]`. Sign: `s = a[N-1] ^ b[N-1]`.
- True quotient: `floor((ma << Q) / mb)`, truncated toward zero. The dividend is N-1+Q = 47 bits, so 47 iterations are needed.
- Each CALC cycle performs one restoring step:
  - Shift the remainder left, bringing in the next dividend bit (MSB first).
  - If remainder >= mb, subtract mb and set the quotient bit to 1; otherwise set it to 0.
- The quotient register is N-1 bits wide. Any 1 shifted out of its top sets a sticky `ovf_r`.
- Result at DONE:
  - If `div_zero`: magnitude = all ones (2^(N-1)-1), sign = `s`.
  - Else if `ovf_r`: magnitude = all ones, sign = `s`.
  - Else: magnitude = quotient register.
  - If the final magnitude is 0, the sign is forced to 0 (no negative zero).
- State machine:
  - IDLE: `in_ready` = 1. On `in_valid`, latch operands and clear the counter, quotient, remainder and `ovf_r`. Go to CALC, or directly to DONE if `mb == 0`.
  - CALC: `in_ready` = 0. Perform one step per cycle. After step 47 (counter == N-1+Q-1), go to DONE.
  - DONE: `out_valid` = 1; `c`, `ovf` and `div_zero` are held stable. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. There is no overlap between a result being held and a new acceptance.
- Reset (at any time, including mid-CALC or in DONE): state = IDLE. After reset:
  - `in_ready` = 1, `out_valid` = 0
  - `c` = 0, `ovf` = 0, `div_zero` = 0
  - Internal registers are cleared, and any in-flight operation is discarded.

## Timing
- The acceptance edge is the edge where `in_valid & in_ready` is high.
- Normal divide: the 47 steps occur on the next 47 edges. `out_valid` rises after the 48th edge following acceptance, i.e. latency is N-1+Q+1 = 48 cycles.
- Divide by zero: `out_valid` rises after the first edge following acceptance, i.e. latency is 1 cycle.
- Output backpressure: while `out_ready` = 0 in DONE, all outputs are held indefinitely.
- The result is consumed on the edge where `out_valid & out_ready` is high. `in_ready` is high in the next cycle. Best-case throughput is one result per 49 cycles.
- `in_valid` is ignored outside IDLE. Operands are sampled only on the acceptance edge and may change afterwards.

## Structure
- Shared package `fixed_point_pkg` holds:
  - Constants `FP_N`, `FP_Q`, `FP_ONE` (32'h0001_0000), `FP_MAG_MAX` (31'h7FFF_FFFF).
  - The `div_state_t` enum {IDLE, CALC, DONE}. The other sequential operators reuse this package.
- One sub-module, `div_step`: combinational single restoring step.
  - Inputs: remainder, next dividend bit, `mb`.
  - Outputs: new remainder, quotient bit.
  - It is unit-testable on its own.
- Top-level contents: FSM, iteration counter (`$clog2(N-1+Q)` bits), operand/remainder/quotient registers, and the saturation/sign output mux.

## Test plan
- 3.0 / 2.0: `a`=32'h0003_0000, `b`=32'h0002_0000 -> `c`=32'h0001_8000, `ovf`=0, `div_zero`=0, `out_valid` exactly 48 cycles after acceptance.
- -1.0 / 4.0: `a`=32'h8001_0000, `b`=32'h0004_0000 -> `c`=32'h8000_4000. Also 1.0 / 3.0 -> 32'h0000_5555 (truncated).
- Divide by zero: `a`=32'h8002_0000, `b`=32'h8000_0000 -> `c`=32'h7FFF_FFFF, `div_zero`=1, `out_valid` 1 cycle after acceptance.
- Overflow: `a`=32'h4000_0000, `b`=32'h0000_0001 -> `c`=32'h7FFF_FFFF, `ovf`=1. Negative-zero case: `a`=32'h8000_0000, `b`=32'h0001_0000 -> `c`=32'h0000_0000.
- Backpressure: hold `out_ready`=0 for 20 cycles in DONE -> `c` and flags stay stable, `in_ready`=0, and a toggling `in_valid` is ignored. Release -> next-cycle `in_ready`=1.
- Reset at cycle 20 of CALC -> next cycle `in_ready`=1, `out_valid`=0, `c`=0. A following 3.0 / 2.0 produces the correct result.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared constants and state encoding for the sign-magnitude Q16.16 sequential operators.
package fixed_point_pkg;

  localparam int FP_N = 32;
  localparam int FP_Q = 16;
  localparam logic [FP_N-1:0] FP_ONE     = 32'h0001_0000;
  localparam logic [FP_N-2:0] FP_MAG_MAX = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_fixed_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int W = 31
) (
  input  logic [W-1:0] rem,
  input  logic         din,
  input  logic [W-1:0] mb,
  output logic [W-1:0] rem_nxt,
  output logic         q
);

  logic [W:0] sh;

  // The incoming remainder is always below mb, so the restored value fits back in W bits.
  always_comb begin
    sh      = {rem, din};
    q       = (sh >= {1'b0, mb});
    rem_nxt = q ? W'(sh - {1'b0, mb}) : sh[W-1:0];
  end

endmodule

// File: rtl/seq_fixed_div.sv
// Multi-cycle radix-2 restoring divider for sign-magnitude fixed point, valid/ready on both sides.
module seq_fixed_div
  import fixed_point_pkg::*;
#(
  parameter int N = FP_N,
  parameter int Q = FP_Q
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         div_zero
);

  localparam int STEPS = N - 1 + Q;   // dividend width = number of iterations
  localparam int CW    = $clog2(STEPS);
  localparam int MW    = N - 1;       // magnitude width

  div_state_t     state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [STEPS-1:0] dvd_r;            // scaled dividend, consumed MSB first
  logic [MW-1:0]  mb_r;
  logic [MW-1:0]  rem_r;
  logic [MW-1:0]  quo_r;
  logic           sign_r;
  logic           ovf_r;
  logic           dz_r;

  logic [MW-1:0]  rem_step;
  logic           q_step;
  logic           accept;
  logic [MW-1:0]  mag;
  logic           sgn;

  div_step #(.W(MW)) u_step (
    .rem     (rem_r),
    .din     (dvd_r[STEPS-1]),
    .mb      (mb_r),
    .rem_nxt (rem_step),
    .q       (q_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (b[N-2:0] == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == CW'(STEPS - 1)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = (state == IDLE) && in_valid;

  // Operand capture on acceptance, then one restoring step per CALC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      dvd_r  <= '0;
      mb_r   <= '0;
      rem_r  <= '0;
      quo_r  <= '0;
      sign_r <= 1'b0;
      ovf_r  <= 1'b0;
      dz_r   <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      dvd_r  <= {a[N-2:0], {Q{1'b0}}};
      mb_r   <= b[N-2:0];
      rem_r  <= '0;
      quo_r  <= '0;
      sign_r <= a[N-1] ^ b[N-1];
      ovf_r  <= 1'b0;
      dz_r   <= (b[N-2:0] == '0);
    end else if (state == CALC) begin
      cnt   <= cnt + CW'(1);
      dvd_r <= {dvd_r[STEPS-2:0], 1'b0};
      rem_r <= rem_step;
      // A quotient bit falling off the top means the magnitude cannot be represented.
      quo_r <= {quo_r[MW-2:0], q_step};
      ovf_r <= ovf_r | quo_r[MW-1];
    end
  end

  // Saturation and sign mux; outputs are zero whenever no result is being presented.
  always_comb begin
    mag      = (dz_r || ovf_r) ? {MW{1'b1}} : quo_r;
    sgn      = sign_r && (mag != '0);
    c        = '0;
    ovf      = 1'b0;
    div_zero = 1'b0;
    if (state == DONE) begin
      c        = {sgn, mag};
      ovf      = ovf_r;
      div_zero = dz_r;
    end
  end

endmodule
